// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - byte-enabled store buffer between the MEM stage and the data RAM
//
// Purpose:
//   Queues core stores in a small FIFO and drains them to the data-RAM write
//   port over a valid/ready handshake. Loads are merged byte-wise with the
//   pending stores so the core always sees program-order data. Stores to the
//   same word as the newest entry are optionally coalesced into it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mem_we/waddr/wdata    store request from the core (any enable bit = store)
//   mem_raddr/mem_rdata   load address from the core, merged load data back
//   stall_o               store presented but refused this cycle
//   empty_o               no pending stores
//   ram_raddr/ram_rdata   RAM read port (address passthrough, comb. data)
//   ram_wvalid/ram_wready RAM write handshake for the head entry
//   ram_waddr/wdata/we    head entry word address, data and byte enables

module dmem_store_buffer #(
   parameter int DEPTH    = 4,
   parameter bit COALESCE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  mem_we,
   input  logic [31:0] mem_waddr,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_raddr,
   output logic [31:0] mem_rdata,
   output logic        stall_o,
   output logic        empty_o,
   output logic [31:0] ram_raddr,
   input  logic [31:0] ram_rdata,
   output logic        ram_wvalid,
   input  logic        ram_wready,
   output logic [31:0] ram_waddr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_we
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW + 1)'(1);

   logic [29:0]   e_word [DEPTH];
   logic [31:0]   e_data [DEPTH];
   logic [3:0]    e_be   [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] newest;
   logic [AW:0]   count;
   logic [AW:0]   count_next;

   logic          store_req;
   logic          pop;
   logic          merge;
   logic          push;
   logic [31:0]   wdata_masked;
   logic [AW-1:0] idx;

   // Word-offset bits of the store address have no meaning at this level.
   logic          unused_waddr_lsb;
   assign unused_waddr_lsb = ^mem_waddr[1:0];

   assign newest     = tail - AW'(1);
   assign store_req  = |mem_we;
   assign empty_o    = (count == '0);
   assign ram_wvalid = !empty_o;
   assign pop        = ram_wvalid && ram_wready;

   // Merging into a single entry that leaves this cycle would lose the
   // update, so that case falls through to a normal push instead.
   assign merge = COALESCE && store_req && (count != '0) &&
                  (e_word[newest] == mem_waddr[31:2]) && !(pop && (count == ONE));
   assign push    = store_req && !merge && ((count != FULL) || pop);
   assign stall_o = store_req && !merge && !push;

   assign ram_raddr = mem_raddr;
   assign ram_waddr = {e_word[head], 2'b00};
   assign ram_wdata = e_data[head];
   assign ram_we    = e_be[head];

   always_comb begin
      wdata_masked = '0;
      for (int b = 0; b < 4; b++) begin
         if (mem_we[b]) wdata_masked[8*b +: 8] = mem_wdata[8*b +: 8];
      end
   end

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + ONE;
      else if (pop && !push) count_next = count - ONE;
   end

   // Oldest to newest so that the youngest matching store wins each lane.
   // The head being popped still counts: the RAM only updates at the edge.
   always_comb begin
      mem_rdata = ram_rdata;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (((AW + 1)'(k) < count) && (e_word[idx] == mem_raddr[31:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (e_be[idx][b]) mem_rdata[8*b +: 8] = e_data[idx][8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_word[i] <= '0;
            e_data[i] <= '0;
            e_be[i]   <= '0;
         end
      end else begin
         if (pop) head <= head + AW'(1);
         if (push) begin
            e_word[tail] <= mem_waddr[31:2];
            e_data[tail] <= wdata_masked;
            e_be[tail]   <= mem_we;
            tail         <= tail + AW'(1);
         end
         if (merge) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_we[b]) e_data[newest][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            e_be[newest] <= e_be[newest] | mem_we;
         end
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed self-checking bench for dmem_store_buffer

module tb_dmem_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  mem_we = 4'h0;
   logic [31:0] mem_waddr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_raddr = '0;
   logic [31:0] ram_rdata = '0;
   logic        ram_wready = 1'b0;

   // a_*: coalescing instance, b_*: non-coalescing instance
   logic [31:0] a_rdata, b_rdata, a_raddr, b_raddr;
   logic [31:0] a_waddr, b_waddr, a_wdata, b_wdata;
   logic [3:0]  a_we, b_we;
   logic        a_stall, b_stall, a_empty, b_empty, a_wvalid, b_wvalid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_store_buffer #(.DEPTH(4), .COALESCE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(a_rdata),
      .stall_o(a_stall), .empty_o(a_empty), .ram_raddr(a_raddr),
      .ram_rdata(ram_rdata), .ram_wvalid(a_wvalid), .ram_wready(ram_wready),
      .ram_waddr(a_waddr), .ram_wdata(a_wdata), .ram_we(a_we)
   );

   dmem_store_buffer #(.DEPTH(4), .COALESCE(1'b0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(b_rdata),
      .stall_o(b_stall), .empty_o(b_empty), .ram_raddr(b_raddr),
      .ram_rdata(ram_rdata), .ram_wvalid(b_wvalid), .ram_wready(ram_wready),
      .ram_waddr(b_waddr), .ram_wdata(b_wdata), .ram_we(b_we)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      ram_wready = 1'b1;
      mem_we     = 4'h0;
      for (int i = 0; i < n; i++) tick();
      ram_wready = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ram_wready = 1'b0; mem_we = 4'h0;
      tick(); tick();
      checks++; if (a_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %h exp 0", a_wvalid); end
      checks++; if (a_we !== 4'h0) begin errors++; $display("FAIL reset_we got %h exp 0", a_we); end
      checks++; if (a_waddr !== 32'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", a_waddr); end
      checks++; if (a_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", a_wdata); end
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %h exp 0", a_stall); end
      checks++; if (a_empty !== 1'b1 || b_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %h/%h exp 1/1", a_empty, b_empty); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_store();
      mem_we = 4'hF; mem_waddr = 32'h100; mem_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (a_wvalid !== 1'b0) begin errors++; $display("FAIL store_latency got wvalid %h exp 0", a_wvalid); end
      tick();
      mem_we = 4'h0;
      #1;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (a_wvalid !== 1'b1 || a_waddr !== 32'h100 || a_we !== 4'hF || a_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold_stable cyc %0d got v=%h a=%h we=%h d=%h exp 1/00000100/f/deadbeef", c, a_wvalid, a_waddr, a_we, a_wdata);
         end
         if (c < 3) tick();
      end
      ram_wready = 1'b1;
      tick();
      ram_wready = 1'b0;
      #1;
      checks++; if (a_empty !== 1'b1 || a_wvalid !== 1'b0) begin errors++; $display("FAIL pop_empty got e=%h v=%h exp 1/0", a_empty, a_wvalid); end
   endtask

   task automatic test_full_stall();
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'hC; exp_addr[3] = 32'h10;
      ram_wready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_we = 4'hF; mem_waddr = 32'(i * 4); mem_wdata = 32'h1000 + 32'(i * 4);
         tick();
      end
      mem_waddr = 32'h10; mem_wdata = 32'h1010;
      #1;
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %h exp 1", a_stall); end
      tick();
      checks++; if (a_stall !== 1'b1 || a_waddr !== 32'h0) begin errors++; $display("FAIL stall_no_change got s=%h a=%h exp 1/00000000", a_stall, a_waddr); end
      ram_wready = 1'b1;
      #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL push_pop_stall got %h exp 0", a_stall); end
      tick();
      mem_we = 4'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (a_waddr !== exp_addr[i] || a_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL drain_order %0d got a=%h v=%h exp %h/1", i, a_waddr, a_wvalid, exp_addr[i]);
         end
         tick();
      end
      ram_wready = 1'b0;
      #1;
      checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %h exp 1", a_empty); end
      drain(6);
   endtask

   task automatic test_load_forward();
      ram_wready = 1'b0;
      mem_we = 4'h1; mem_waddr = 32'h200; mem_wdata = 32'h000000AA;
      tick();
      mem_we = 4'h0; ram_rdata = 32'h11223344; mem_raddr = 32'h200;
      #1;
      checks++; if (a_rdata !== 32'h112233AA || b_rdata !== 32'h112233AA) begin errors++; $display("FAIL fwd_lane0 got %h/%h exp 112233aa", a_rdata, b_rdata); end
      checks++; if (a_raddr !== 32'h200) begin errors++; $display("FAIL raddr_pass got %h exp 00000200", a_raddr); end
      mem_we = 4'h1; mem_waddr = 32'h204; mem_wdata = 32'h000000BB;
      tick();
      mem_we = 4'h0;
      #1;
      checks++; if (a_rdata !== 32'h112233AA) begin errors++; $display("FAIL fwd_other_word got %h exp 112233aa", a_rdata); end
      mem_raddr = 32'h204;
      #1;
      checks++; if (a_rdata !== 32'h112233BB) begin errors++; $display("FAIL fwd_204 got %h exp 112233bb", a_rdata); end
      mem_raddr = 32'h200; mem_we = 4'h2; mem_waddr = 32'h200; mem_wdata = 32'h0000CC00;
      #1;
      checks++; if (a_rdata !== 32'h112233AA) begin errors++; $display("FAIL no_same_cycle_fwd got %h exp 112233aa", a_rdata); end
      mem_we = 4'h0;
      drain(4);
      checks++; if (a_empty !== 1'b1 || b_empty !== 1'b1) begin errors++; $display("FAIL fwd_drain got %h/%h exp 1/1", a_empty, b_empty); end
   endtask

   task automatic test_coalesce();
      ram_wready = 1'b0;
      mem_we = 4'h3; mem_waddr = 32'h300; mem_wdata = 32'h00001234;
      tick();
      mem_we = 4'hC; mem_wdata = 32'h56780000;
      tick();
      mem_we = 4'h0; mem_raddr = 32'h300; ram_rdata = 32'h0;
      #1;
      checks++; if (a_we !== 4'hF || a_wdata !== 32'h56781234) begin errors++; $display("FAIL coalesce_head got we=%h d=%h exp f/56781234", a_we, a_wdata); end
      checks++; if (b_we !== 4'h3 || b_wdata !== 32'h00001234) begin errors++; $display("FAIL nc_head got we=%h d=%h exp 3/00001234", b_we, b_wdata); end
      checks++; if (a_rdata !== 32'h56781234 || b_rdata !== 32'h56781234) begin errors++; $display("FAIL coalesce_load got %h/%h exp 56781234", a_rdata, b_rdata); end
      ram_wready = 1'b1;
      tick();
      ram_wready = 1'b0;
      #1;
      checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL coalesce_one_entry got empty %h exp 1", a_empty); end
      checks++; if (b_empty !== 1'b0 || b_we !== 4'hC || b_wdata !== 32'h56780000) begin errors++; $display("FAIL nc_second got e=%h we=%h d=%h exp 0/c/56780000", b_empty, b_we, b_wdata); end
      drain(3);
      checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL nc_drain got %h exp 1", b_empty); end
   endtask

   task automatic test_merge_pop_boundary();
      ram_wready = 1'b0;
      mem_we = 4'h1; mem_waddr = 32'h600; mem_wdata = 32'h00000011;
      tick();
      ram_wready = 1'b1; mem_we = 4'h2; mem_wdata = 32'h00002200;
      #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL pop_last_stall got %h exp 0", a_stall); end
      tick();
      ram_wready = 1'b0; mem_we = 4'h0;
      #1;
      checks++; if (a_empty !== 1'b0 || a_we !== 4'h2 || a_wdata !== 32'h00002200) begin errors++; $display("FAIL pop_last_push got e=%h we=%h d=%h exp 0/2/00002200", a_empty, a_we, a_wdata); end
      drain(3);
   endtask

   task automatic test_newest_wins();
      ram_wready = 1'b0;
      mem_we = 4'h1; mem_waddr = 32'h400; mem_wdata = 32'h00000001;
      tick();
      mem_wdata = 32'h00000002;
      tick();
      mem_we = 4'h0; mem_raddr = 32'h400; ram_rdata = 32'hFFFFFFFF;
      #1;
      checks++; if (a_rdata !== 32'hFFFFFF02 || b_rdata !== 32'hFFFFFF02) begin errors++; $display("FAIL newest_wins got %h/%h exp ffffff02", a_rdata, b_rdata); end
      checks++; if (b_wdata !== 32'h00000001) begin errors++; $display("FAIL nc_oldest_head got %h exp 00000001", b_wdata); end
      drain(4);
   endtask

   task automatic test_reset_mid_drain();
      ram_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_we = 4'hF; mem_waddr = 32'h500 + 32'(i * 4); mem_wdata = 32'hA0 + 32'(i);
         tick();
      end
      mem_we = 4'h0;
      ram_wready = 1'b1;
      tick();
      checks++; if (a_empty !== 1'b0 || a_waddr !== 32'h504) begin errors++; $display("FAIL pre_reset got e=%h a=%h exp 0/00000504", a_empty, a_waddr); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (a_wvalid !== 1'b0 || a_empty !== 1'b1 || b_wvalid !== 1'b0) begin errors++; $display("FAIL async_reset got v=%h e=%h vb=%h exp 0/1/0", a_wvalid, a_empty, b_wvalid); end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (a_wvalid !== 1'b0 || b_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL stale_write cyc %0d got %h/%h exp 0/0", c, a_wvalid, b_wvalid);
         end
      end
      ram_wready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_full_stall();
      test_load_forward();
      test_coalesce();
      test_merge_pop_boundary();
      test_newest_wins();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
